mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 136 +++++++++++++
 tb/tb_mdu_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: computes mult/div results on the start edge and
// holds them for a fixed number of busy cycles before committing them to HI/LO.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mdOp_Ex,
    input  logic [31:0] opA_Ex,
    input  logic [31:0] opB_Ex,
    input  logic        rdSel_Ex,
    input  logic        mdUse_Id,
    output logic        busy,
    output logic        start,
    output logic        ifStallMd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdRd_Ex
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [4:0] MUL_LOAD = 5'(MULT_CYC - 1);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYC - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} stateT;

    stateT       state, stateNext;
    logic [4:0]  cnt, cntNext;
    logic [31:0] hiNext, loNext;
    logic [31:0] resHi, resLo, resHiNext, resLoNext;

    // Arithmetic datapath; operands are widened explicitly so the 64-bit products are exact.
    logic [63:0] aSext, bSext, aZext, bZext, mulS, mulU;
    logic [31:0] quoRaw, remRaw, quoS, remS, quoU, remU;
    logic        divOvf, divZero;

    assign aSext  = {{32{opA_Ex[31]}}, opA_Ex};
    assign bSext  = {{32{opB_Ex[31]}}, opB_Ex};
    assign aZext  = {32'd0, opA_Ex};
    assign bZext  = {32'd0, opB_Ex};
    assign mulS   = aSext * bSext;
    assign mulU   = aZext * bZext;

    assign divZero = (opB_Ex == 32'd0);
    assign divOvf  = (opA_Ex == 32'h8000_0000) && (opB_Ex == 32'hFFFF_FFFF);
    assign quoRaw  = $signed(opA_Ex) / $signed(opB_Ex);
    assign remRaw  = $signed(opA_Ex) % $signed(opB_Ex);
    // The most-negative / -1 case is pinned explicitly rather than left to the divider.
    assign quoS    = divOvf ? 32'h8000_0000 : quoRaw;
    assign remS    = divOvf ? 32'd0 : remRaw;
    assign quoU    = opA_Ex / opB_Ex;
    assign remU    = opA_Ex % opB_Ex;

    assign busy      = (state != IDLE);
    assign ifStallMd = mdUse_Id && (busy || start);
    assign mdRd_Ex   = rdSel_Ex ? hi : lo;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        stateNext = state;
        cntNext   = cnt;
        hiNext    = hi;
        loNext    = lo;
        resHiNext = resHi;
        resLoNext = resLo;
        start     = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (mdOp_Ex)
                    OP_MULT, OP_MULTU: begin
                        start     = 1'b1;
                        {resHiNext, resLoNext} = (mdOp_Ex == OP_MULT) ? mulS : mulU;
                        cntNext   = MUL_LOAD;
                        stateNext = MUL;
                    end
                    OP_DIV, OP_DIVU: begin
                        start     = 1'b1;
                        cntNext   = DIV_LOAD;
                        stateNext = DIV;
                        // Divide by zero re-commits the current HI/LO, which cannot change while busy.
                        if (divZero) begin
                            resHiNext = hi;
                            resLoNext = lo;
                        end else if (mdOp_Ex == OP_DIV) begin
                            resHiNext = remS;
                            resLoNext = quoS;
                        end else begin
                            resHiNext = remU;
                            resLoNext = quoU;
                        end
                    end
                    OP_MTHI: hiNext = opA_Ex;
                    OP_MTLO: loNext = opA_Ex;
                    default: ;
                endcase
            end
            MUL, DIV: begin
                if (cnt == 5'd0) begin
                    hiNext    = resHi;
                    loNext    = resLo;
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - 5'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            resHi <= 32'd0;
            resLo <= 32'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            hi    <= hiNext;
            lo    <= loNext;
            resHi <= resHiNext;
            resLo <= resLoNext;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random traffic compared
// against a cycle-count reference model of HI/LO and the busy window.
module tb_mdu_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mdOp_Ex;
    logic [31:0] opA_Ex, opB_Ex;
    logic        rdSel_Ex, mdUse_Id;
    logic        busy, start, ifStallMd;
    logic [31:0] hi, lo, mdRd_Ex;

    mdu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .mdOp_Ex(mdOp_Ex), .opA_Ex(opA_Ex), .opB_Ex(opB_Ex),
        .rdSel_Ex(rdSel_Ex), .mdUse_Id(mdUse_Id), .busy(busy), .start(start),
        .ifStallMd(ifStallMd), .hi(hi), .lo(lo), .mdRd_Ex(mdRd_Ex)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining busy cycles and the result waiting to be committed.
    int          remaining;
    logic [31:0] mHi, mLo, pendHi, pendLo;

    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] curHi,
                                              input logic [31:0] curLo);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = {curHi, curLo};
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: res = ua * ub;
            3'd3: if (b != 0) begin
                sq  = sa / sb;
                sr  = sa % sb;
                res = {sr[31:0], sq[31:0]};
            end
            3'd4: if (b != 0) res = {a % b, a / b};
            default: ;
        endcase
        return res;
    endfunction

    task automatic modelEdge(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
                mHi = pendHi;
                mLo = pendLo;
            end
        end else begin
            case (op)
                3'd1, 3'd2: begin
                    {pendHi, pendLo} = refResult(op, a, b, mHi, mLo);
                    remaining = MULT_CYC;
                end
                3'd3, 3'd4: begin
                    {pendHi, pendLo} = refResult(op, a, b, mHi, mLo);
                    remaining = DIV_CYC;
                end
                3'd5: mHi = a;
                3'd6: mLo = a;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance both.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rd, input logic use_);
        logic expBusy, expStart;
        mdOp_Ex  = op;
        opA_Ex   = a;
        opB_Ex   = b;
        rdSel_Ex = rd;
        mdUse_Id = use_;
        #1;
        expBusy  = (remaining > 0);
        expStart = !expBusy && (op >= 3'd1) && (op <= 3'd4);
        chk("busy",  {31'd0, busy},      {31'd0, expBusy});
        chk("start", {31'd0, start},     {31'd0, expStart});
        chk("stall", {31'd0, ifStallMd}, {31'd0, use_ && (expBusy || expStart)});
        chk("hi",    hi, mHi);
        chk("lo",    lo, mLo);
        chk("mdRd",  mdRd_Ex, rd ? mHi : mLo);
        @(posedge clk);
        modelEdge(op, a, b);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic use_);
        for (int i = 0; i < n; i++) step(3'd0, 32'd0, 32'd0, i[0], use_);
    endtask

    initial begin
        reset = 1'b0;
        mdOp_Ex = 3'd0; opA_Ex = 32'd0; opB_Ex = 32'd0; rdSel_Ex = 1'b0; mdUse_Id = 1'b0;
        remaining = 0; mHi = 32'd0; mLo = 32'd0; pendHi = 32'd0; pendLo = 32'd0;

        // Reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mdRd", mdRd_Ex, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // mult / multu -2 * 3, stall held from the start cycle
        step(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
        idle(MULT_CYC, 1'b1);
        chk("mult_stall_clear", {31'd0, ifStallMd}, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        step(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        idle(MULT_CYC, 1'b0);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        // div -7 / 2, then divu by zero keeps HI/LO
        step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DIV_CYC, 1'b0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        step(3'd4, 32'd7, 32'd0, 1'b1, 1'b0);
        idle(DIV_CYC, 1'b0);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        // mtlo while busy is ignored; mtlo in IDLE lands next cycle
        step(3'd1, 32'd9, 32'd9, 1'b0, 1'b0);
        step(3'd6, 32'h1234, 32'd0, 1'b0, 1'b0);
        idle(MULT_CYC - 1, 1'b0);
        chk("mtlo_busy_lo", lo, 32'd81);
        step(3'd6, 32'h1234, 32'd0, 1'b0, 1'b0);
        chk("mtlo_idle_lo", lo, 32'h1234);
        chk("mtlo_idle_busy", {31'd0, busy}, 32'd0);

        // Signed overflow
        step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DIV_CYC, 1'b0);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // Back-to-back mult then div in cycle T+6
        step(3'd1, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(MULT_CYC, 1'b0);
        chk("b2b_mult_lo", lo, 32'd700);
        step(3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(DIV_CYC, 1'b0);
        chk("b2b_div_lo", lo, 32'd14);
        chk("b2b_div_hi", hi, 32'd2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 15))
                0, 1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 5));
                default: ;
            endcase
            step(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(DIV_CYC + 1, 1'b0);

        // Reset in busy cycle 3 of a div aborts it with no late write-back
        step(3'd5, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0);
        step(3'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
        idle(2, 1'b0);
        reset = 1'b0;
        #1;
        remaining = 0; mHi = 32'd0; mLo = 32'd0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_mdRd", mdRd_Ex, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(DIV_CYC + 2, 1'b0);
        chk("abort_after_hi", hi, 32'd0);
        chk("abort_after_lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
